alu_muldiv: RTL and testbench

- Iterative multi-cycle RV32M execution unit covering MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in the EX stage; the pipeline stalls on in_ready/out_valid.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.
- Valid/ready handshake on both sides, flush abort, and a fast path for divide special cases.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_signfix.sv | 37 +++
 rtl/alu_muldiv.sv | 131 +++++++++++++
 tb/tb_alu_muldiv.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and operation-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_signed_a(input op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Applies the final two's-complement correction to the magnitude results and picks
// the product half, quotient or remainder the operation asks for.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  op_e                       op,
  input  logic [2*DATA_WIDTH-1:0]   prod,
  input  logic [DATA_WIDTH-1:0]     quo,
  input  logic [DATA_WIDTH-1:0]     rem,
  input  logic                      neg_res,
  input  logic                      neg_rem,
  output logic [DATA_WIDTH-1:0]     result
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;

  assign prod_s = neg_res ? -prod : prod;
  assign quo_s  = neg_res ? -quo  : quo;
  assign rem_s  = neg_rem ? -rem  : rem;

  always_comb begin
    result = rem_s;
    unique case (op)
      OP_MUL:                      result = prod_s[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*W-1:W];
      OP_DIV, OP_DIVU:             result = quo_s;
      default:                     result = rem_s;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M execution unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a same-cycle fast path for divide-by-zero and signed overflow.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3,
  parameter int CNT_WIDTH     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    Result,
  output logic                     busy
);

  localparam int W = DATA_WIDTH;

  state_e               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  op_e                  op;
  logic                 neg_res, neg_rem;
  logic [2*W-1:0]       mcand, prod;
  logic [W-1:0]         shreg;     // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [W-1:0]         divisor;
  logic [W:0]           rem;

  op_e            op_in;
  logic           neg_a, neg_b, div_zero, div_ovf, fast, accept;
  logic [W-1:0]   mag_a, mag_b, fast_res, fix_res;
  logic [W:0]     rem_sh, trial;

  assign op_in    = op_e'(Operation[2:0]);
  assign neg_a    = is_signed_a(op_in) && SrcA[W-1];
  assign neg_b    = is_signed_b(op_in) && SrcB[W-1];
  assign mag_a    = neg_a ? -SrcA : SrcA;
  assign mag_b    = neg_b ? -SrcB : SrcB;
  assign div_zero = is_div(op_in) && (SrcB == '0);
  assign div_ovf  = is_div(op_in) && is_signed_b(op_in) &&
                    (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
  assign fast     = div_zero || div_ovf;
  assign accept   = in_valid && (state == IDLE) && !flush;

  // Operation bit 1 separates REM/REMU from DIV/DIVU within the divide group.
  always_comb begin
    fast_res = '1;
    if (op_in[1])      fast_res = div_zero ? SrcA : '0;
    else if (div_ovf)  fast_res = {1'b1, {(W-1){1'b0}}};
  end

  assign rem_sh = {rem[W-1:0], shreg[W-1]};
  assign trial  = rem_sh - {1'b0, divisor};

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == CNT_WIDTH'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  muldiv_signfix #(.DATA_WIDTH(W)) u_signfix (
    .op      (op),
    .prod    (prod),
    .quo     (shreg),
    .rem     (rem[W-1:0]),
    .neg_res (neg_res),
    .neg_rem (neg_rem),
    .result  (fix_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      op      <= OP_MUL;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      mcand   <= '0;
      prod    <= '0;
      shreg   <= '0;
      divisor <= '0;
      rem     <= '0;
      Result  <= '0;
    end else if (accept) begin
      cnt     <= CNT_WIDTH'(W);
      op      <= op_in;
      neg_res <= neg_a ^ neg_b;
      neg_rem <= neg_a;
      mcand   <= {{W{1'b0}}, mag_a};
      prod    <= '0;
      shreg   <= is_div(op_in) ? mag_a : mag_b;
      divisor <= mag_b;
      rem     <= '0;
      if (fast) Result <= fast_res;
    end else if (state == CALC && !flush) begin
      // One quotient bit or one partial product per cycle.
      cnt <= cnt - CNT_WIDTH'(1);
      if (is_div(op)) begin
        rem   <= trial[W] ? rem_sh : trial;
        shreg <= {shreg[W-2:0], ~trial[W]};
      end else begin
        if (shreg[0]) prod <= prod + mcand;
        mcand <= mcand << 1;
        shreg <= shreg >> 1;
      end
    end else if (state == FIX && !flush) begin
      Result <= fix_res;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: operation table, fast path, backpressure, flush and async reset.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [2:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        in_ready, out_valid, busy;
  logic [31:0] Result;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .busy      (busy)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one op, scrambles inputs while busy, measures latency, then hands the result off.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    tick();
    SrcA = ~a; SrcB = ~b; Operation = ~op;
    n = 1;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, Result, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Operation = 3'd0; SrcA = '0; SrcB = '0;
    vecs = '{
      '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd34},
      '{3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 8'd34},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd34},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd34},
      '{3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 8'd34},
      '{3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 8'd34},
      '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 8'd1},
      '{3'd7, 32'd100,       32'd0,         32'd100,       8'd1},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd1},
      '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 8'd34},
      '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         8'd34},
      '{3'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25,        8'd34},
      '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 8'd34}
    };

    tick();
    tick();
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_result",    Result,             32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
             int'(vecs[i].lat));

    // Backpressure: result must hold while the consumer stalls.
    Operation = 3'd0; SrcA = 32'd12; SrcB = 32'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 1;
    while (!out_valid && seen < 200) begin tick(); seen++; end
    chk("bp_lat", seen, 32'd34);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp_res%0d", k), Result, 32'd156);
      chk($sformatf("bp_vld%0d", k), {31'b0, out_valid}, 32'd1);
      chk($sformatf("bp_rdy%0d", k), {31'b0, in_ready}, 32'd0);
      chk($sformatf("bp_busy%0d", k), {31'b0, busy}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_rdy",  {31'b0, in_ready},  32'd1);
    chk("bp_idle_vld",  {31'b0, out_valid}, 32'd0);
    chk("bp_idle_busy", {31'b0, busy},      32'd0);

    // Flush in CALC cycle 10.
    Operation = 3'd5; SrcA = 32'd1000; SrcB = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("fl_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy",   {31'b0, busy},      32'd0);
    chk("fl_rdy",    {31'b0, in_ready},  32'd1);
    chk("fl_vld",    {31'b0, out_valid}, 32'd0);
    chk("fl_result", Result,             32'd156);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("fl_no_vld", seen, 32'd0);
    run_op("after_flush", 3'd5, 32'd1000, 32'd7, 32'd142, 34);

    // Flush in IDLE blocks a pending accept.
    Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd3; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_idle_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset between edges mid-CALC.
    Operation = 3'd3; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("ar_busy_before", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_vld",    {31'b0, out_valid}, 32'd0);
    chk("ar_rdy",    {31'b0, in_ready},  32'd1);
    chk("ar_busy",   {31'b0, busy},      32'd0);
    chk("ar_result", Result,             32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_op("after_reset", 3'd7, 32'd1000, 32'd7, 32'd6, 34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
